// File: rtl/por_sequencer.sv
// rtl/por_sequencer.sv - power-on-reset sequencer with debounce, staged release and brown-out recovery
// Each power-good is synchronised and debounced; resets are released in index order after a hold delay.
module por_sequencer #(
  parameter int NCH      = 2,
  parameter int DEBOUNCE = 16,
  parameter int HOLD     = 64,
  parameter int CNT_W    = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [NCH-1:0] pgood_i,
  input  logic           enable_i,
  input  logic           clr_fault_i,
  output logic [NCH-1:0] rst_n_o,
  output logic [NCH-1:0] stable_o,
  output logic [3:0]     stage_o,
  output logic           done_o,
  output logic           fault_o,
  output logic [2:0]     fault_ch_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DELAY = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [3:0]       LAST_S    = 4'(NCH);

  logic [NCH-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NCH-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0] deb_q [NCH];
  logic [CNT_W-1:0] deb_d [NCH];
  logic [1:0]       state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             fault_q, fault_d;
  logic [2:0]       ch_q, ch_d;

  logic             bo_hit;
  logic [2:0]       bo_idx;
  logic             stable_cur;

  // Debounce counter saturates at DEBOUNCE; stable is a registered view of saturation.
  always_comb begin
    sync1_d = pgood_i;
    sync2_d = sync1_q;
    for (int k = 0; k < NCH; k++) begin
      deb_d[k]    = '0;
      stable_d[k] = (deb_q[k] == DEB_MAX);
      if (sync2_q[k]) begin
        deb_d[k] = (deb_q[k] == DEB_MAX) ? deb_q[k] : deb_q[k] + CNT_W'(1);
      end
    end
  end

  // Descending scan so the lowest released domain that lost power wins.
  always_comb begin
    bo_hit     = 1'b0;
    bo_idx     = '0;
    stable_cur = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if ((4'(k) < s_q) && !stable_q[k]) begin
        bo_hit = 1'b1;
        bo_idx = 3'(k);
      end
      if (4'(k) == s_q) begin
        stable_cur = stable_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    hold_d  = hold_q;
    fault_d = fault_q;
    ch_d    = ch_q;
    if (clr_fault_i) begin
      fault_d = 1'b0;
      ch_d    = '0;
    end
    if (!enable_i) begin
      state_d = ST_IDLE;
      s_d     = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_WAIT;
    end else if (bo_hit) begin
      state_d = ST_WAIT;
      s_d     = {1'b0, bo_idx};
      fault_d = 1'b1;
      ch_d    = bo_idx;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (stable_cur) begin
            hold_d  = '0;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (!stable_cur) begin
            state_d = ST_WAIT;
          end else if (hold_q == HOLD_LAST) begin
            s_d     = s_q + 4'd1;
            state_d = (s_q + 4'd1 == LAST_S) ? ST_RUN : ST_WAIT;
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        deb_q[k] <= '0;
      end
      state_q  <= ST_IDLE;
      s_q      <= '0;
      hold_q   <= '0;
      fault_q  <= 1'b0;
      ch_q     <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int k = 0; k < NCH; k++) begin
        deb_q[k] <= deb_d[k];
      end
      state_q  <= state_d;
      s_q      <= s_d;
      hold_q   <= hold_d;
      fault_q  <= fault_d;
      ch_q     <= ch_d;
    end
  end

  always_comb begin
    rst_n_o = '0;
    for (int k = 0; k < NCH; k++) begin
      rst_n_o[k] = (4'(k) < s_q);
    end
  end

  assign stable_o   = stable_q;
  assign stage_o    = s_q;
  assign done_o     = (s_q == LAST_S);
  assign fault_o    = fault_q;
  assign fault_ch_o = ch_q;

endmodule
